// File: rtl/cosx_pkg.sv
// Shared types and widths for the CosX job sequencer: operand/result widths,
// FSM state encoding and the operand FIFO word.
package cosx_pkg;

  localparam int X_W = 10;
  localparam int Y_W = 8;
  localparam int R_W = 10;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_LOW  = 2'd2,
    WAIT_HIGH = 2'd3
  } cosx_seq_state_t;

  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
  } cosx_op_t;

endpackage

// File: rtl/cosx_job_sequencer_if.sv
// Operand input, accelerator and result output bundle of the CosX job sequencer.
// master = surrounding system (producer, accelerator, consumer); slave = sequencer.
interface cosx_job_sequencer_if
  import cosx_pkg::*;
#(
  parameter int TAG_W = 4
);

  logic             in_valid;
  logic             in_ready;
  logic [X_W-1:0]   in_x;
  logic [Y_W-1:0]   in_y;

  logic             acc_start;
  logic [X_W-1:0]   acc_x;
  logic [Y_W-1:0]   acc_y;
  logic [R_W-1:0]   acc_result;
  logic             acc_ready;

  logic             out_valid;
  logic             out_ready;
  logic [R_W-1:0]   out_result;
  logic [TAG_W-1:0] out_tag;

  logic             busy;

  modport master (
    output in_valid, in_x, in_y, acc_result, acc_ready, out_ready,
    input  in_ready, acc_start, acc_x, acc_y, out_valid, out_result, out_tag, busy
  );

  modport slave (
    input  in_valid, in_x, in_y, acc_result, acc_ready, out_ready,
    output in_ready, acc_start, acc_x, acc_y, out_valid, out_result, out_tag, busy
  );

endinterface

// File: rtl/cosx_op_fifo.sv
// Synchronous operand FIFO; pointers carry one extra wrap bit so full/empty
// fall out of a plain pointer compare.
module cosx_op_fifo
  import cosx_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  logic     pop,
  input  cosx_op_t wdata,
  output cosx_op_t rdata,
  output logic     full,
  output logic     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr, rd_ptr;
  cosx_op_t    mem [DEPTH];
  logic        do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage carries no reset; emptiness is defined by the pointers alone.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/cosx_job_sequencer.sv
// Buffers operand pairs, runs one CosX accelerator job at a time and returns
// tagged results on a valid/ready port. COSX_SEQ_STATS_EN adds job/busy counters.
module cosx_job_sequencer
  import cosx_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  cosx_job_sequencer_if.slave  bus
`ifdef COSX_SEQ_STATS_EN
  ,
  output logic [15:0]          stat_jobs,
  output logic [15:0]          stat_busy_cycles
`endif
);

  cosx_seq_state_t  state;
  cosx_op_t         head;
  logic             full, empty, push, pop, capture;
  logic [TAG_W-1:0] tag_cnt;

  logic             start_q;
  logic [X_W-1:0]   x_q;
  logic [Y_W-1:0]   y_q;
  logic             out_valid_q;
  logic [R_W-1:0]   out_result_q;
  logic [TAG_W-1:0] out_tag_q;

  assign push = bus.in_valid && !full;
  // Issue only when the result register is free or being drained this cycle.
  assign pop = (state == IDLE) && !empty && bus.acc_ready &&
               (!out_valid_q || bus.out_ready);
  assign capture = (state == WAIT_HIGH) && bus.acc_ready;

  cosx_op_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata ('{x: bus.in_x, y: bus.in_y}),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      start_q      <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_tag_q    <= '0;
      tag_cnt      <= '0;
    end else begin
      start_q <= 1'b0;
      if (out_valid_q && bus.out_ready) out_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            x_q     <= head.x;
            y_q     <= head.y;
            start_q <= 1'b1;
            state   <= START;
          end
        end
        START: state <= WAIT_LOW;
        WAIT_LOW: begin
          if (!bus.acc_ready) state <= WAIT_HIGH;
        end
        WAIT_HIGH: begin
          if (bus.acc_ready) begin
            out_result_q <= bus.acc_result;
            out_tag_q    <= tag_cnt;
            out_valid_q  <= 1'b1;
            tag_cnt      <= tag_cnt + 1'b1;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready   = !full;
  assign bus.acc_start  = start_q;
  assign bus.acc_x      = x_q;
  assign bus.acc_y      = y_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_result = out_result_q;
  assign bus.out_tag    = out_tag_q;
  assign bus.busy       = (state != IDLE) || !empty;

`ifdef COSX_SEQ_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_jobs        <= '0;
      stat_busy_cycles <= '0;
    end else begin
      if (capture && stat_jobs != 16'hFFFF)
        stat_jobs <= stat_jobs + 16'd1;
      if (state != IDLE && stat_busy_cycles != 16'hFFFF)
        stat_busy_cycles <= stat_busy_cycles + 16'd1;
    end
  end
`endif

endmodule
